// File: rtl/rom_arbiter_if.sv
// Valid/ready request + response channel between one requester and the ROM arbiter.
// master = requester side, slave = arbiter side.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_addr, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_arbiter.sv
// Two-port arbiter sharing one synchronous single-port ROM, one read in flight at a time.
// ROM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins); default is round-robin.
module rom_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rom_arbiter_if.slave          port0_if,
  rom_arbiter_if.slave          port1_if,
  output logic                  rom_rd_ena_o,
  output logic [ADDR_WIDTH-1:0] rom_address_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic gnt0, gnt1;
  logic owner_rsp_ready;

`ifdef ROM_ARB_FIXED_PRIO_EN
  assign gnt0 = port0_if.req_valid;
  assign gnt1 = port1_if.req_valid && !port0_if.req_valid;
`else
  // On contention the port that did not win last time is served.
  assign gnt0 = port0_if.req_valid && (!port1_if.req_valid || last_grant_q);
  assign gnt1 = port1_if.req_valid && (!port0_if.req_valid || !last_grant_q);
`endif

  assign owner_rsp_ready = owner_q ? port1_if.rsp_ready : port0_if.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    rsp_data_d   = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (gnt0) begin
          state_d      = StIssue;
          owner_d      = 1'b0;
          last_grant_d = 1'b0;
          addr_d       = port0_if.req_addr;
        end else if (gnt1) begin
          state_d      = StIssue;
          owner_d      = 1'b1;
          last_grant_d = 1'b1;
          addr_d       = port1_if.req_addr;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        rsp_data_d = rom_data_i;
        state_d    = StResp;
      end
      StResp: begin
        if (owner_rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    port0_if.req_ready = (state_q == StIdle) && gnt0;
    port1_if.req_ready = (state_q == StIdle) && gnt1;
    port0_if.rsp_valid = (state_q == StResp) && !owner_q;
    port1_if.rsp_valid = (state_q == StResp) && owner_q;
    port0_if.rsp_data  = rsp_data_q;
    port1_if.rsp_data  = rsp_data_q;
    rom_rd_ena_o       = (state_q == StIssue);
    rom_address_o      = addr_q;
    busy_o             = (state_q != StIdle);
  end

endmodule
